// File: rtl/myc64_bus_pkg.sv
// Shared constants for the C64 bus slot arbiter: grant encodings, default
// phase timing and the VIC cycle-steal predicate.
package myc64_bus_pkg;

   localparam logic [2:0] GNT_VIC = 3'b001;
   localparam logic [2:0] GNT_CPU = 3'b010;
   localparam logic [2:0] GNT_EXT = 3'b100;

   localparam int DIV_DEF      = 8;
   localparam int PH2_OFS_DEF  = 4;
   localparam int CNT_RST_DEF  = 5;
   localparam int BA_GRACE_DEF = 3;

   // The VIC takes a phi2 slot once BA is low and the CPU write grace has run out.
   function automatic logic vic_steals(input logic ba, input logic grace_zero);
      return (!ba) && grace_zero;
   endfunction

endpackage

// File: rtl/myc64_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; used for buffering loader writes.
module myc64_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

   logic [PW:0]      wr_ptr_q;
   logic [PW:0]      wr_ptr_d;
   logic [PW:0]      rd_ptr_q;
   logic [PW:0]      rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   // Status decode and pointer advance; the top pointer bit separates full from empty.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      level     = wr_ptr_q - rd_ptr_q;
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      dout      = mem_q[rd_ptr_q[PW-1:0]];
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {(PW + 1){1'b0}};
         rd_ptr_q <= {(PW + 1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage, cleared on reset so stale loader data never reaches memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q[PW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/myc64_bus_slot_arb.sv
// C64 phase generator and shared-memory slot arbiter between VIC, CPU and an
// external loader, with BA cycle stealing and a buffered loader write path.
module myc64_bus_slot_arb
   import myc64_bus_pkg::*;
#(
   parameter int DIV       = DIV_DEF,
   parameter int PH2_OFS   = PH2_OFS_DEF,
   parameter int CNT_RST   = CNT_RST_DEF,
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int EXT_DEPTH = 4,
   parameter int BA_GRACE  = BA_GRACE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   output logic          o_ph1_en,
   output logic          o_ph2_en,
   output logic          o_vic_cycle,
   input  logic [AW-1:0] i_vic_addr,
   input  logic          i_vic_ba,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic          i_cpu_we,
   input  logic [DW-1:0] i_cpu_wdata,
   output logic          o_cpu_rdy,
   input  logic          i_ext_valid,
   input  logic [AW-1:0] i_ext_addr,
   input  logic [DW-1:0] i_ext_data,
   output logic          o_ext_ready,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_we,
   output logic [DW-1:0] o_mem_wdata,
   output logic [2:0]    o_grant
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW = (BA_GRACE > 0) ? $clog2(BA_GRACE + 1) : 1;
   localparam int LW = $clog2(EXT_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_PH2    = CW'(PH2_OFS);
   localparam logic [CW-1:0] CNT_INIT   = CW'(CNT_RST);
   localparam logic [GW-1:0] GRACE_INIT = GW'(BA_GRACE);

   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [GW-1:0]    grace_q;
   logic [GW-1:0]    grace_d;
   logic [2:0]       grant_q;
   logic [2:0]       grant_d;
   logic [AW-1:0]    mem_addr_q;
   logic [AW-1:0]    mem_addr_d;
   logic             mem_we_q;
   logic             mem_we_d;
   logic [DW-1:0]    mem_wdata_q;
   logic [DW-1:0]    mem_wdata_d;
   logic             vic_cycle_q;
   logic             vic_cycle_d;
   logic             cpu_rdy_q;
   logic             cpu_rdy_d;

   logic             ph1_en_s;
   logic             ph2_en_s;
   logic             steal_s;
   logic             fifo_push_s;
   logic             fifo_pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [LW-1:0]    fifo_level_s;
   logic [AW+DW-1:0] fifo_dout_s;

   assign ph1_en_s    = (cnt_q == {CW{1'b0}});
   assign ph2_en_s    = (cnt_q == CNT_PH2);
   assign steal_s     = vic_steals(i_vic_ba, grace_q == {GW{1'b0}});
   assign fifo_push_s = i_ext_valid && !fifo_full_s;

   myc64_sync_fifo #(
      .WIDTH (AW + DW),
      .DEPTH (EXT_DEPTH)
   ) u_ext_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .din   ({i_ext_addr, i_ext_data}),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   // Phase counter and BA grace counter next state.
   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? {CW{1'b0}} : (cnt_q + CW'(1));
      if (i_vic_ba) begin
         grace_d = GRACE_INIT;
      end else if (ph2_en_s && (grace_q != {GW{1'b0}})) begin
         grace_d = grace_q - GW'(1);
      end else begin
         grace_d = grace_q;
      end
   end

   // Owner selection at each half-cycle boundary; all memory outputs hold in between.
   always_comb begin
      grant_d     = grant_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      vic_cycle_d = vic_cycle_q;
      cpu_rdy_d   = cpu_rdy_q;
      fifo_pop_s  = 1'b0;
      if (ph1_en_s) begin
         grant_d     = GNT_VIC;
         mem_addr_d  = i_vic_addr;
         mem_we_d    = 1'b0;
         mem_wdata_d = {DW{1'b0}};
         vic_cycle_d = 1'b0;
         // RDY predicts whether the coming phi2 slot will belong to the CPU.
         cpu_rdy_d   = !(steal_s || (fifo_level_s != {LW{1'b0}}));
      end else if (ph2_en_s) begin
         vic_cycle_d = 1'b1;
         if (steal_s) begin
            grant_d     = GNT_VIC;
            mem_addr_d  = i_vic_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = {DW{1'b0}};
         end else if (!fifo_empty_s) begin
            grant_d     = GNT_EXT;
            mem_addr_d  = fifo_dout_s[AW+DW-1:DW];
            mem_we_d    = 1'b1;
            mem_wdata_d = fifo_dout_s[DW-1:0];
            fifo_pop_s  = 1'b1;
         end else begin
            grant_d     = GNT_CPU;
            mem_addr_d  = i_cpu_addr;
            mem_we_d    = i_cpu_we;
            mem_wdata_d = i_cpu_wdata;
         end
      end else begin
         grant_d = grant_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= CNT_INIT;
         grace_q     <= GRACE_INIT;
         grant_q     <= GNT_CPU;
         mem_addr_q  <= {AW{1'b0}};
         mem_we_q    <= 1'b0;
         mem_wdata_q <= {DW{1'b0}};
         vic_cycle_q <= 1'b0;
         cpu_rdy_q   <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         grace_q     <= grace_d;
         grant_q     <= grant_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         vic_cycle_q <= vic_cycle_d;
         cpu_rdy_q   <= cpu_rdy_d;
      end
   end

   assign o_ph1_en    = ph1_en_s;
   assign o_ph2_en    = ph2_en_s;
   assign o_vic_cycle = vic_cycle_q;
   assign o_cpu_rdy   = cpu_rdy_q;
   assign o_ext_ready = !fifo_full_s;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_grant     = grant_q;

endmodule

// File: tb/tb_myc64_bus_slot_arb.sv
// Scenario bench for myc64_bus_slot_arb with a queue-based slot model
// checked every cycle during a randomized run.
module tb_myc64_bus_slot_arb;
   import myc64_bus_pkg::*;

   localparam int DIV = 8, PH2_OFS = 4, CNT_RST = 5, AW = 16, DW = 8;
   localparam int EXT_DEPTH = 4, BA_GRACE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ph1_en, ph2_en, vic_cycle, cpu_rdy, ext_ready, mem_we;
   logic vic_ba = 1'b1, cpu_we = 1'b0, ext_valid = 1'b0;
   logic [AW-1:0] vic_addr = '0, cpu_addr = '0, ext_addr = '0, mem_addr;
   logic [DW-1:0] cpu_wdata = '0, ext_data = '0, mem_wdata;
   logic [2:0] grant;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   myc64_bus_slot_arb #(
      .DIV(DIV), .PH2_OFS(PH2_OFS), .CNT_RST(CNT_RST), .AW(AW), .DW(DW),
      .EXT_DEPTH(EXT_DEPTH), .BA_GRACE(BA_GRACE)
   ) dut (
      .clk(clk), .rst(rst_n), .o_ph1_en(ph1_en), .o_ph2_en(ph2_en),
      .o_vic_cycle(vic_cycle), .i_vic_addr(vic_addr), .i_vic_ba(vic_ba),
      .i_cpu_addr(cpu_addr), .i_cpu_we(cpu_we), .i_cpu_wdata(cpu_wdata),
      .o_cpu_rdy(cpu_rdy), .i_ext_valid(ext_valid), .i_ext_addr(ext_addr),
      .i_ext_data(ext_data), .o_ext_ready(ext_ready), .o_mem_addr(mem_addr),
      .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .o_grant(grant)
   );

   // Reference model: slot owner per half-cycle from the arbitration rules,
   // loader buffer as a queue, grace as a count of remaining CPU slots.
   int t;
   int m_ph;
   int m_grace;
   bit m_acc;
   logic [AW+DW-1:0] mq[$];
   logic [AW+DW-1:0] m_e;
   logic [2:0] e_grant;
   logic e_we, e_rdy, e_vc;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t = 0; mq.delete(); m_grace = BA_GRACE;
         e_grant = GNT_CPU; e_we = 1'b0; e_rdy = 1'b1; e_vc = 1'b0;
         e_addr = '0; e_wdata = '0;
      end else begin
         m_ph = (CNT_RST + t) % DIV;
         m_acc = ext_valid && (mq.size() < EXT_DEPTH);
         if (m_ph == 0) begin
            e_grant = GNT_VIC; e_we = 1'b0; e_addr = vic_addr; e_wdata = '0; e_vc = 1'b0;
            e_rdy = !((!vic_ba && m_grace == 0) || mq.size() != 0);
         end else if (m_ph == PH2_OFS) begin
            e_vc = 1'b1;
            if (!vic_ba && m_grace == 0) begin
               e_grant = GNT_VIC; e_we = 1'b0; e_addr = vic_addr; e_wdata = '0;
            end else if (mq.size() != 0) begin
               m_e = mq.pop_front();
               e_grant = GNT_EXT; e_we = 1'b1; e_addr = m_e[AW+DW-1:DW]; e_wdata = m_e[DW-1:0];
            end else begin
               e_grant = GNT_CPU; e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
            end
         end
         if (vic_ba) m_grace = BA_GRACE;
         else if (m_ph == PH2_OFS && m_grace > 0) m_grace = m_grace - 1;
         if (m_acc) mq.push_back({ext_addr, ext_data});
         t = t + 1;
      end
   end

   function automatic int phase();
      return (CNT_RST + t) % DIV;
   endfunction

   task automatic goto_phase(input int p);
      for (int i = 0; i < 2 * DIV && phase() != p; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (grant !== 3'b010) begin bad++; $display("FAIL reset_grant: got %b want 010", grant); end
      total++; if ({ph1_en, ph2_en, mem_we, vic_cycle} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags: got %b want 0000", {ph1_en, ph2_en, mem_we, vic_cycle}); end
      total++; if ({cpu_rdy, ext_ready} !== 2'b11) begin
         bad++; $display("FAIL reset_rdy: got %b want 11", {cpu_rdy, ext_ready}); end
      total++; if ({mem_addr, mem_wdata} !== {AW+DW{1'b0}}) begin
         bad++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata}); end
      rst_n = 1'b1;
   endtask

   task automatic test_phase();
      logic x1, x2, xv;
      logic [2:0] xg;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         x1 = ((CNT_RST + k) % DIV == 0);
         x2 = ((CNT_RST + k) % DIV == PH2_OFS);
         xg = (((CNT_RST - 1 + k) % DIV) < PH2_OFS) ? GNT_VIC : GNT_CPU;
         xv = (k >= 8) && (((CNT_RST - 1 + k) % DIV) >= PH2_OFS);
         total++; if ({ph1_en, ph2_en} !== {x1, x2}) begin
            bad++; $display("FAIL phase_en k=%0d: got %b want %b", k, {ph1_en, ph2_en}, {x1, x2}); end
         total++; if ({grant, vic_cycle} !== {xg, xv}) begin
            bad++; $display("FAIL phase_grant k=%0d: got %b want %b", k, {grant, vic_cycle}, {xg, xv}); end
      end
   endtask

   task automatic test_cpu_write();
      cpu_addr = 16'h0400; cpu_wdata = 8'h41; cpu_we = 1'b1;
      goto_phase(PH2_OFS);
      for (int i = 1; i <= DIV - PH2_OFS; i++) begin
         @(negedge clk);
         total++; if ({grant, mem_we, mem_addr, mem_wdata} !== {GNT_CPU, 1'b1, 16'h0400, 8'h41}) begin
            bad++; $display("FAIL cpu_write i=%0d: got %h want %h", i, {grant, mem_we, mem_addr, mem_wdata},
                            {GNT_CPU, 1'b1, 16'h0400, 8'h41}); end
      end
      @(negedge clk);
      total++; if ({grant, mem_we} !== {GNT_VIC, 1'b0}) begin
         bad++; $display("FAIL cpu_write_ph1: got %b want %b", {grant, mem_we}, {GNT_VIC, 1'b0}); end
      cpu_we = 1'b0;
   endtask

   task automatic test_grace();
      logic [2:0] xg;
      cpu_we = 1'b1; cpu_addr = 16'($urandom);
      goto_phase(PH2_OFS + 1);
      vic_ba = 1'b0;
      for (int s = 1; s <= 6; s++) begin
         goto_phase(PH2_OFS);
         total++; if (cpu_rdy !== (s <= BA_GRACE)) begin
            bad++; $display("FAIL grace_rdy slot=%0d: got %b want %b", s, cpu_rdy, s <= BA_GRACE); end
         @(negedge clk);
         xg = (s <= BA_GRACE) ? GNT_CPU : GNT_VIC;
         total++; if ({grant, mem_we} !== {xg, s <= BA_GRACE}) begin
            bad++; $display("FAIL grace_slot slot=%0d: got %b want %b", s, {grant, mem_we}, {xg, s <= BA_GRACE}); end
      end
      vic_ba = 1'b1; cpu_we = 1'b0;
      goto_phase(PH2_OFS); @(negedge clk);
      total++; if ({grant, cpu_rdy} !== {GNT_CPU, 1'b1}) begin
         bad++; $display("FAIL grace_end: got %b want %b", {grant, cpu_rdy}, {GNT_CPU, 1'b1}); end
   endtask

   task automatic test_burst();
      logic [DW-1:0] d[5];
      int w;
      for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
      goto_phase(PH2_OFS + 1);
      for (int c = 0; c < 4; c++) begin
         ext_valid = 1'b1; ext_addr = 16'hC000 + 16'(c); ext_data = d[c];
         @(negedge clk);
      end
      ext_addr = 16'hC004; ext_data = d[4];
      total++; if ({ext_ready, cpu_rdy} !== 2'b00) begin
         bad++; $display("FAIL burst_full: got %b want 00", {ext_ready, cpu_rdy}); end
      w = 0;
      while (!ext_ready && w < 2 * DIV) begin @(negedge clk); w++; end
      total++; if (!ext_ready || phase() != PH2_OFS + 1) begin
         bad++; $display("FAIL burst_refill: got ready=%b phase=%0d want ready=1 phase=%0d", ext_ready, phase(), PH2_OFS + 1); end
      @(negedge clk);
      ext_valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
         if (s > 0) begin
            goto_phase(PH2_OFS);
            total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL burst_rdy slot=%0d: got %b want 0", s, cpu_rdy); end
            @(negedge clk);
         end
         total++; if ({grant, mem_we, mem_addr, mem_wdata} !== {GNT_EXT, 1'b1, 16'hC000 + 16'(s), d[s]}) begin
            bad++; $display("FAIL burst_slot s=%0d: got %h want %h", s, {grant, mem_we, mem_addr, mem_wdata},
                            {GNT_EXT, 1'b1, 16'hC000 + 16'(s), d[s]}); end
      end
      goto_phase(PH2_OFS); @(negedge clk);
      total++; if ({grant, cpu_rdy} !== {GNT_CPU, 1'b1}) begin
         bad++; $display("FAIL burst_end: got %b want %b", {grant, cpu_rdy}, {GNT_CPU, 1'b1}); end
   endtask

   task automatic test_simul();
      logic [AW-1:0] a[4];
      for (int i = 0; i < 4; i++) a[i] = 16'($urandom);
      goto_phase(PH2_OFS + 1);
      for (int c = 0; c < 3; c++) begin
         ext_valid = 1'b1; ext_addr = a[c]; ext_data = 8'(c); @(negedge clk);
      end
      ext_valid = 1'b0;
      goto_phase(PH2_OFS);
      ext_valid = 1'b1; ext_addr = a[3]; ext_data = 8'd3;
      @(negedge clk);
      ext_valid = 1'b0;
      total++; if ({ext_ready, grant, mem_addr} !== {1'b1, GNT_EXT, a[0]}) begin
         bad++; $display("FAIL simul_pushpop: got %h want %h", {ext_ready, grant, mem_addr}, {1'b1, GNT_EXT, a[0]}); end
      for (int s = 1; s <= 4; s++) begin
         goto_phase(PH2_OFS); @(negedge clk);
         if (s < 4) begin
            total++; if ({grant, mem_addr, mem_wdata} !== {GNT_EXT, a[s], 8'(s)}) begin
               bad++; $display("FAIL simul_drain s=%0d: got %h want %h", s, {grant, mem_addr, mem_wdata}, {GNT_EXT, a[s], 8'(s)}); end
         end else begin
            total++; if (grant !== GNT_CPU) begin bad++; $display("FAIL simul_level: got %b want %b", grant, GNT_CPU); end
         end
      end
   endtask

   task automatic test_reset_mid();
      goto_phase(PH2_OFS + 1);
      for (int c = 0; c < 3; c++) begin
         ext_valid = 1'b1; ext_addr = 16'hD000 + 16'(c); ext_data = 8'hA0; @(negedge clk);
      end
      ext_valid = 1'b0;
      goto_phase(PH2_OFS); @(negedge clk);
      total++; if ({grant, mem_we} !== {GNT_EXT, 1'b1}) begin
         bad++; $display("FAIL rstmid_pre: got %b want %b", {grant, mem_we}, {GNT_EXT, 1'b1}); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({mem_we, grant, ext_ready, cpu_rdy} !== {1'b0, GNT_CPU, 2'b11}) begin
         bad++; $display("FAIL rstmid_async: got %b want %b", {mem_we, grant, ext_ready, cpu_rdy}, {1'b0, GNT_CPU, 2'b11}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      total++; if ({grant, mem_we} !== {GNT_CPU, 1'b0}) begin
         bad++; $display("FAIL rstmid_empty: got %b want %b", {grant, mem_we}, {GNT_CPU, 1'b0}); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         total++; if ({ph1_en, ph2_en, cpu_rdy, ext_ready, vic_cycle} !==
                      {phase() == 0, phase() == PH2_OFS, e_rdy, mq.size() < EXT_DEPTH, e_vc}) begin
            bad++; $display("FAIL rand_ctl i=%0d: got %b want %b", i, {ph1_en, ph2_en, cpu_rdy, ext_ready, vic_cycle},
                            {phase() == 0, phase() == PH2_OFS, e_rdy, mq.size() < EXT_DEPTH, e_vc}); end
         total++; if ({grant, mem_we, mem_addr, mem_wdata} !== {e_grant, e_we, e_addr, e_wdata}) begin
            bad++; $display("FAIL rand_bus i=%0d: got %h want %h", i, {grant, mem_we, mem_addr, mem_wdata},
                            {e_grant, e_we, e_addr, e_wdata}); end
         if (phase() == 2 && ($urandom % 3) == 0) vic_ba = ~vic_ba;
         vic_addr = 16'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         cpu_we = 1'($urandom); ext_valid = (($urandom % 4) == 0);
         ext_addr = 16'($urandom); ext_data = 8'($urandom);
      end
      vic_ba = 1'b1; ext_valid = 1'b0; cpu_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_phase();
      test_cpu_write();
      test_grace();
      test_burst();
      test_simul();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
